// File: rtl/ddr3_pkg.sv
// Shared constants and state encoding for the DDR3 command arbiter.
package ddr3_pkg;

  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam int         BURST_BITS = 128;
  localparam int         MASK_BITS  = BURST_BITS / 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WCMD = 2'd2,
    ST_RCMD = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ddr3_cmd_arbiter_rd_credit_counter.sv
// Outstanding-read counter: +1 per issued read command, -1 per completed
// read burst. at_limit blocks further read grants; underflow flags a
// return that had no matching command (count is held at zero).
module rd_credit_counter #(
  parameter int MAX_READS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic       at_limit,
  output logic       underflow,
  output logic [3:0] count
);

  logic [3:0] count_reg;
  logic [3:0] count_next;

  // Next count; simultaneous inc and dec cancel out.
  always_comb begin
    count_next = count_reg;
    underflow  = 1'b0;
    if (inc && !dec) begin
      count_next = count_reg + 4'd1;
    end else if (dec && !inc) begin
      if (count_reg == 4'd0) begin
        underflow = 1'b1;
      end else begin
        count_next = count_reg - 4'd1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 4'd0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign at_limit = (count_reg >= 4'(MAX_READS));
  assign count    = count_reg;

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter sharing the GoWin DDR3 controller command/write/read
// ports between one write requester and one read requester. Each command is
// a single BL8 burst (one 128-bit beat).
// Optional: define DDR3_ARB_STATS_EN to add saturating command counters.
module ddr3_cmd_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int MAX_READS  = 4
) (
  input  logic                  ddr_clock,
  input  logic                  ddr_rst_n,
  input  logic                  calib_done,
  input  logic                  wq_valid,
  output logic                  wq_ready,
  input  logic [ADDR_WIDTH-1:0] wq_addr,
  input  logic [MASK_BITS-1:0]  wq_stb_n,
  input  logic [BURST_BITS-1:0] wq_data,
  input  logic                  rq_valid,
  output logic                  rq_ready,
  input  logic [ADDR_WIDTH-1:0] rq_addr,
  output logic                  rr_valid,
  output logic [BURST_BITS-1:0] rr_data,
  output logic                  dc_valid,
  input  logic                  dc_ready,
  output logic [2:0]            dc_command,
  output logic [ADDR_WIDTH-1:0] dc_addr,
  output logic [5:0]            dc_blength,
  output logic                  dw_valid,
  input  logic                  dw_ready,
  output logic                  dw_last,
  output logic [MASK_BITS-1:0]  dw_stb_n,
  output logic [BURST_BITS-1:0] dw_data,
  input  logic                  dr_valid,
  input  logic                  dr_last,
  input  logic [BURST_BITS-1:0] dr_data
`ifdef DDR3_ARB_STATS_EN
  ,
  output logic [15:0]           stat_writes,
  output logic [15:0]           stat_reads
`endif
);

  arb_state_t            state_reg, state_next;
  logic                  last_read_reg;   // 1: last grant went to the reader
  logic                  write_grant, read_grant;
  logic                  dc_valid_reg, dw_valid_reg;
  logic [2:0]            dc_command_reg;
  logic [ADDR_WIDTH-1:0] dc_addr_reg;
  logic [MASK_BITS-1:0]  dw_stb_n_reg;
  logic [BURST_BITS-1:0] dw_data_reg;
  logic                  rr_valid_reg;
  logic [BURST_BITS-1:0] rr_data_reg;
  logic                  credit_at_limit, credit_underflow;
  logic [3:0]            credit_count;

  rd_credit_counter #(.MAX_READS(MAX_READS)) u_credit (
    .clk       (ddr_clock),
    .rst_n     (ddr_rst_n),
    .inc       ((state_reg == ST_RCMD) && dc_ready),
    .dec       (dr_valid && dr_last),
    .at_limit  (credit_at_limit),
    .underflow (credit_underflow),
    .count     (credit_count)
  );

  // Next state and grant decision; grants only ever happen in IDLE.
  always_comb begin
    state_next  = state_reg;
    write_grant = 1'b0;
    read_grant  = 1'b0;
    case (state_reg)
      ST_INIT: if (calib_done) state_next = ST_IDLE;
      ST_IDLE: begin
        if (wq_valid && (!(rq_valid && !credit_at_limit) || last_read_reg)) begin
          write_grant = 1'b1;
          state_next  = ST_WCMD;
        end else if (rq_valid && !credit_at_limit) begin
          read_grant = 1'b1;
          state_next = ST_RCMD;
        end
      end
      // Both the command and the data beat must be taken, in either order.
      ST_WCMD: if ((!dc_valid_reg || dc_ready) && (!dw_valid_reg || dw_ready))
                 state_next = ST_IDLE;
      ST_RCMD: if (dc_ready) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge ddr_clock or negedge ddr_rst_n) begin
    if (!ddr_rst_n) state_reg <= ST_INIT;
    else            state_reg <= state_next;
  end

  // Capture the granted request into the controller-facing registers and
  // drop each valid on its own handshake.
  always_ff @(posedge ddr_clock or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      last_read_reg  <= 1'b1;
      dc_valid_reg   <= 1'b0;
      dc_command_reg <= 3'b000;
      dc_addr_reg    <= '0;
      dw_valid_reg   <= 1'b0;
      dw_stb_n_reg   <= '0;
      dw_data_reg    <= '0;
    end else if (write_grant) begin
      last_read_reg  <= 1'b0;
      dc_valid_reg   <= 1'b1;
      dc_command_reg <= CMD_WRITE;
      dc_addr_reg    <= wq_addr;
      dw_valid_reg   <= 1'b1;
      dw_stb_n_reg   <= wq_stb_n;
      dw_data_reg    <= wq_data;
    end else if (read_grant) begin
      last_read_reg  <= 1'b1;
      dc_valid_reg   <= 1'b1;
      dc_command_reg <= CMD_READ;
      dc_addr_reg    <= rq_addr;
    end else begin
      if (dc_ready) dc_valid_reg <= 1'b0;
      if (dw_ready) dw_valid_reg <= 1'b0;
    end
  end

  // Read return path: one register stage, no backpressure.
  always_ff @(posedge ddr_clock or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      rr_valid_reg <= 1'b0;
      rr_data_reg  <= '0;
    end else begin
      rr_valid_reg <= dr_valid;
      rr_data_reg  <= dr_data;
    end
  end

  // A return with nothing outstanding means the requester or controller lost track.
  always_ff @(posedge ddr_clock) begin
    assert (!(ddr_rst_n && credit_underflow))
      else $error("ddr3_cmd_arbiter: read return with no outstanding read (count %0d)", credit_count);
  end

`ifdef DDR3_ARB_STATS_EN
  logic [15:0] stat_writes_reg, stat_reads_reg;

  // Count controller-accepted commands by type, saturating at all-ones.
  always_ff @(posedge ddr_clock or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      stat_writes_reg <= 16'h0000;
      stat_reads_reg  <= 16'h0000;
    end else if (dc_valid_reg && dc_ready) begin
      if (dc_command_reg == CMD_WRITE && stat_writes_reg != 16'hFFFF)
        stat_writes_reg <= stat_writes_reg + 16'd1;
      if (dc_command_reg == CMD_READ && stat_reads_reg != 16'hFFFF)
        stat_reads_reg <= stat_reads_reg + 16'd1;
    end
  end

  assign stat_writes = stat_writes_reg;
  assign stat_reads  = stat_reads_reg;
`endif

  assign wq_ready   = write_grant;
  assign rq_ready   = read_grant;
  assign dc_valid   = dc_valid_reg;
  assign dc_command = dc_command_reg;
  assign dc_addr    = dc_addr_reg;
  assign dc_blength = 6'h00;
  assign dw_valid   = dw_valid_reg;
  assign dw_last    = dw_valid_reg;
  assign dw_stb_n   = dw_stb_n_reg;
  assign dw_data    = dw_data_reg;
  assign rr_valid   = rr_valid_reg;
  assign rr_data    = rr_data_reg;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed testbench for ddr3_cmd_arbiter: inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
module tb_ddr3_cmd_arbiter;
  import ddr3_pkg::*;

  localparam int AW = 27;

  logic           ddr_clock = 1'b0;
  logic           ddr_rst_n = 1'b0;
  logic           calib_done = 1'b0;
  logic           wq_valid = 1'b0, rq_valid = 1'b0;
  logic           wq_ready, rq_ready;
  logic [AW-1:0]  wq_addr = '0, rq_addr = '0;
  logic [15:0]    wq_stb_n = '0;
  logic [127:0]   wq_data = '0;
  logic           rr_valid;
  logic [127:0]   rr_data;
  logic           dc_valid, dc_ready = 1'b1;
  logic [2:0]     dc_command;
  logic [AW-1:0]  dc_addr;
  logic [5:0]     dc_blength;
  logic           dw_valid, dw_ready = 1'b1, dw_last;
  logic [15:0]    dw_stb_n;
  logic [127:0]   dw_data;
  logic           dr_valid = 1'b0, dr_last = 1'b0;
  logic [127:0]   dr_data = '0;

  int checks = 0;
  int errors = 0;
  logic [2:0]    log_cmd[$];
  logic [AW-1:0] log_addr[$];

  always #5 ddr_clock = ~ddr_clock;

  ddr3_cmd_arbiter #(.ADDR_WIDTH(AW), .MAX_READS(4)) dut (
    .ddr_clock (ddr_clock), .ddr_rst_n (ddr_rst_n), .calib_done (calib_done),
    .wq_valid (wq_valid), .wq_ready (wq_ready), .wq_addr (wq_addr),
    .wq_stb_n (wq_stb_n), .wq_data (wq_data),
    .rq_valid (rq_valid), .rq_ready (rq_ready), .rq_addr (rq_addr),
    .rr_valid (rr_valid), .rr_data (rr_data),
    .dc_valid (dc_valid), .dc_ready (dc_ready), .dc_command (dc_command),
    .dc_addr (dc_addr), .dc_blength (dc_blength),
    .dw_valid (dw_valid), .dw_ready (dw_ready), .dw_last (dw_last),
    .dw_stb_n (dw_stb_n), .dw_data (dw_data),
    .dr_valid (dr_valid), .dr_last (dr_last), .dr_data (dr_data)
  );

  // One line per controller command handshake.
  always @(negedge ddr_clock) begin
    if (ddr_rst_n && dc_valid && dc_ready) begin
      log_cmd.push_back(dc_command);
      log_addr.push_back(dc_addr);
      $display("[%0t] cmd %03b addr 0x%07h", $time, dc_command, dc_addr);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr_clock);
    #1;
  endtask

  task automatic sample();
    @(negedge ddr_clock);
  endtask

  int bad;
  int nw, nr;
  logic [2:0] exp_cmd;

  initial begin
    // Reset state
    wq_valid = 1'b1; rq_valid = 1'b1;
    sample();
    check("rst_dc_valid", dc_valid, 0);
    check("rst_dw_valid", dw_valid, 0);
    check("rst_readies", {wq_ready, rq_ready}, 0);
    check("rst_rr_valid", rr_valid, 0);
    check("rst_blength", dc_blength, 0);

    // Init gating: requests pending, no calibration
    tick(); ddr_rst_n = 1'b1;
    wq_addr = 27'h0000100; wq_data = {16{8'hA5}}; wq_stb_n = 16'h0000;
    rq_addr = 27'h0003000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); sample();
      bad += int'(wq_ready | rq_ready | dc_valid);
    end
    check("init_gate", bad, 0);
    tick(); calib_done = 1'b1; sample();
    check("init_still_waiting", wq_ready, 0);
    tick(); sample();
    check("init_grant_write", {wq_ready, rq_ready}, 2'b10);

    // Write only
    tick(); wq_valid = 1'b0; rq_valid = 1'b0; sample();
    check("wr_dc_valid", dc_valid, 1);
    check("wr_cmd", dc_command, CMD_WRITE);
    check("wr_addr", dc_addr, 27'h0000100);
    check("wr_dw_valid_last", {dw_valid, dw_last}, 2'b11);
    check("wr_data", dw_data, {16{8'hA5}});
    check("wr_no_ready_in_wcmd", {wq_ready, rq_ready}, 0);
    tick(); sample();
    check("wr_done", {dc_valid, dw_valid}, 0);

    // Skewed write handshake (cycle 0 = acceptance)
    tick(); wq_valid = 1'b1; wq_addr = 27'h0000400; wq_data = {16{8'h11}};
    wq_stb_n = 16'h00F0; dc_ready = 1'b1; dw_ready = 1'b0; sample();
    check("sk_c0_ready", wq_ready, 1);
    tick(); wq_addr = 27'h0000500; wq_data = {16{8'h22}}; sample();
    check("sk_c1_valids", {dc_valid, dw_valid}, 2'b11);
    bad = int'(wq_ready);
    for (int c = 2; c <= 5; c++) begin
      tick(); if (c == 5) dw_ready = 1'b1; sample();
      check("sk_dc_dropped", dc_valid, 0);
      check("sk_dw_held", dw_valid, 1);
      bad += int'(wq_ready);
    end
    check("sk_no_early_grant", bad, 0);
    check("sk_data_stable", {dw_stb_n, dw_data}, {16'h00F0, {16{8'h11}}});
    tick(); sample();
    check("sk_c6", {dw_valid, dc_valid, wq_ready}, 3'b001);
    tick(); wq_valid = 1'b0; sample();
    check("sk_c7_next_cmd", {dc_valid, dc_addr}, {1'b1, 27'h0000500});
    tick(); sample();
    check("sk_c8_idle", {dc_valid, dw_valid}, 0);

    // One completed read, then a read stuck in RCMD
    tick(); rq_valid = 1'b1; rq_addr = 27'h0003000; sample();
    check("rd_ready", rq_ready, 1);
    tick(); rq_addr = 27'h0003008; sample();
    check("rd_cmd", {dc_valid, dc_command, dc_addr}, {1'b1, CMD_READ, 27'h0003000});
    tick(); dc_ready = 1'b0; sample();
    check("rd2_ready", rq_ready, 1);
    tick(); rq_valid = 1'b0; sample();
    check("rd2_stuck", {dc_valid, dc_addr}, {1'b1, 27'h0003008});
    check("rd_count_one", dut.u_credit.count_reg, 4'd1);

    // Reset mid-RCMD
    tick(); ddr_rst_n = 1'b0; #1;
    check("rst_async_dc_valid", dc_valid, 0);
    tick(); tick(); ddr_rst_n = 1'b1; dc_ready = 1'b1;
    dr_valid = 1'b1; dr_last = 1'b0; dr_data = {4{32'hDEADBEEF}}; sample();
    check("rst_state_init", dut.state_reg, ST_INIT);
    check("rst_count_zero", dut.u_credit.count_reg, 4'd0);
    tick(); dr_valid = 1'b0; sample();
    check("rst_rr_forward", {rr_valid, rr_data}, {1'b1, {4{32'hDEADBEEF}}});

    // Contention: 8 commands, alternating from write
    tick(); log_cmd.delete(); log_addr.delete();
    wq_valid = 1'b1; rq_valid = 1'b1; wq_addr = 27'h0002000; rq_addr = 27'h0003000;
    for (int i = 0; i < 60 && log_cmd.size() < 8; i++) tick();
    wq_valid = 1'b0; rq_valid = 1'b0;
    tick(); tick(); tick();
    check("ct_num_cmds", log_cmd.size(), 8);
    nw = 0; nr = 0;
    for (int i = 0; i < log_cmd.size() && i < 8; i++) begin
      exp_cmd = (i % 2 == 0) ? CMD_WRITE : CMD_READ;
      check($sformatf("ct_order_%0d", i), log_cmd[i], exp_cmd);
      check($sformatf("ct_addr_%0d", i), log_addr[i],
            (i % 2 == 0) ? 27'h0002000 : 27'h0003000);
      if (log_cmd[i] == CMD_WRITE) nw++; else nr++;
    end
    check("ct_writes", nw, 4);
    check("ct_reads", nr, 4);

    // Return the four outstanding reads
    for (int k = 0; k < 4; k++) begin
      tick(); dr_valid = 1'b1; dr_last = 1'b1; dr_data = {4{32'hC0DE0000 + 32'(k)}}; sample();
      check("ret_not_yet", rr_valid, 0);
      tick(); dr_valid = 1'b0; dr_last = 1'b0; sample();
      check($sformatf("ret_data_%0d", k), {rr_valid, rr_data}, {1'b1, {4{32'hC0DE0000 + 32'(k)}}});
    end

    // Credit limit: six reads wanted, four allowed
    tick(); log_cmd.delete(); log_addr.delete(); rq_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick(); sample();
      if (i >= 12) bad += int'(rq_ready);
    end
    check("cl_four_issued", log_cmd.size(), 4);
    check("cl_ready_low", bad, 0);
    tick(); dr_valid = 1'b1; dr_last = 1'b1; dr_data = '0;
    tick(); dr_valid = 1'b0; dr_last = 1'b0;
    for (int i = 0; i < 10 && log_cmd.size() < 5; i++) tick();
    rq_valid = 1'b0;
    tick(); tick();
    check("cl_fifth_issued", log_cmd.size(), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
